unsigned_divider_seq: RTL



---
 rtl/unsigned_divider_seq.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/unsigned_divider_seq.sv
// unsigned_divider_seq
//
// Sequential unsigned restoring divider: quot = a / b, rem = a % b, one
// quotient bit per clock. Both sides use valid/ready handshakes.
//
// Handshake semantics (input and output alike): a transfer happens on a
// rising clk edge where valid and ready are both high. A producer holding
// valid keeps its data stable until that edge; out_valid is never withdrawn
// without a completed transfer. in_ready is high only in IDLE (and low while
// rst_n is asserted), so at most one operation is in flight.
//
// Parameters:
//   DW  dividend / quotient width (>= 2)
//   VW  divisor / remainder width (1 <= VW <= DW)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid
//   in_ready   block can accept operands (IDLE only)
//   a [DW]     dividend, sampled at the accept edge only
//   b [VW]     divisor, sampled at the accept edge only
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   quot [DW]  quotient, holds last result (or 0 after reset)
//   rem  [VW]  remainder, holds last result (or 0 after reset)
//   div_zero   result came from b == 0 (quot all ones, rem 0)
//
// Build option:
//   DIV_EARLY_OUT_EN  when defined, b == 0 and a < b finish one edge after
//                     accept instead of after DW BUSY steps. Results are
//                     identical in both builds; only latency changes.
//
// The FSM state is held in state_q (IDLE/BUSY/DONE) for checkers to bind to.

module unsigned_divider_seq #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a,
  input  logic [VW-1:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quot,
  output logic [VW-1:0] rem,
  output logic          div_zero
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  // Dividend shift register; quotient bits enter at the LSB as dividend bits
  // leave at the MSB, so after DW steps it holds the quotient.
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW-1:0] div_q, div_d;
  // Partial remainder. After each step it is < b, so VW bits suffice; the
  // VW+1-bit shifted value r' only exists combinationally below.
  logic [VW-1:0] r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          zero_q, zero_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dz_q, dz_d;

  logic [VW:0]   r_shift;
  logic          ge;
  logic [VW-1:0] r_next;
  logic [DW-1:0] q_next;

  always_comb begin
    r_shift = {r_q, dvd_q[DW-1]};
    ge      = (r_shift >= {1'b0, div_q});
    // True difference is < b, so the VW-bit modular subtraction is exact.
    r_next  = ge ? (r_shift[VW-1:0] - div_q) : r_shift[VW-1:0];
    q_next  = {dvd_q[DW-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    div_d   = div_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d   = a;
          div_d   = b;
          r_d     = '0;
          cnt_d   = CW'(DW - 1);
          zero_d  = (b == '0);
          state_d = BUSY;
`ifdef DIV_EARLY_OUT_EN
          if (b == '0) begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = '0;
            dz_d    = 1'b1;
          end else if (a < DW'(b)) begin
            // a < b also means a fits in VW bits, so the slice is exact.
            state_d = DONE;
            quot_d  = '0;
            rem_d   = a[VW-1:0];
            dz_d    = 1'b0;
          end
`endif
        end
      end
      BUSY: begin
        dvd_d = q_next;
        r_d   = r_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          if (zero_q) begin
            quot_d = '1;
            rem_d  = '0;
            dz_d   = 1'b1;
          end else begin
            quot_d = q_next;
            rem_d  = r_next;
            dz_d   = 1'b0;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      div_q   <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      div_q   <= div_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  // Gate with rst_n so in_ready is low during reset even though the state
  // register already reads IDLE.
  assign in_ready  = rst_n & (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quot      = quot_q;
  assign rem       = rem_q;
  assign div_zero  = dz_q;

endmodule
